// File: rtl/result_display_driver_if.sv
// Upstream result bus feeding the display driver: a capture strobe plus the
// signed-magnitude result and its flags.
interface result_display_driver_if;
  logic       load;
  logic [4:0] result;
  logic       divbyzero;
  logic       zero;

  // Strobe semantics: no valid/ready pair. load is a single-cycle capture
  // strobe that the consumer honours on every edge; there is no backpressure.
  modport master (output load, output result, output divbyzero, output zero);
  modport slave  (input  load, input  result, input  divbyzero, input  zero);
endinterface

// File: rtl/result_display_driver.sv
// Captures a 5-bit signed-magnitude result and drives a 4-digit multiplexed
// common-anode 7-segment display (sign, tens, units, or "Err").
module result_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  result_display_driver_if.slave   up,
  output logic [3:0]               an,
  output logic [6:0]               seg,
  output logic                     err
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [4:0]       cap_res;
  logic             cap_dbz;
  logic             cap_zero;
  logic             have_data;

  logic [3:0] mag;
  logic       tens;
  logic [3:0] units;
  logic [6:0] dig_seg;
  logic [3:0] an_next;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Magnitude is at most 15, so the tens digit is only ever 0 or 1.
  always_comb begin
    mag   = cap_res[3:0];
    tens  = (mag >= 4'd10);
    units = tens ? (mag - 4'd10) : mag;
  end

  always_comb begin
    dig_seg = SEG_BLANK;
    an_next = ~(4'b0001 << idx);
    if (have_data) begin
      if (cap_dbz) begin
        case (idx)
          2'd2:       dig_seg = SEG_E;
          2'd1, 2'd0: dig_seg = SEG_R;
          default:    dig_seg = SEG_BLANK;
        endcase
      end else if (cap_zero) begin
        if (idx == 2'd0) dig_seg = SEG_ZERO;
      end else begin
        case (idx)
          2'd0:    dig_seg = bcd_to_seg(units);
          2'd1:    dig_seg = tens ? SEG_ONE : SEG_BLANK;
          2'd3:    dig_seg = (cap_res[4] && mag != 4'd0) ? SEG_MINUS : SEG_BLANK;
          default: dig_seg = SEG_BLANK;
        endcase
      end
    end
  end

  // Scan timing is independent of load so captures never shift the digit phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_res   <= 5'd0;
      cap_dbz   <= 1'b0;
      cap_zero  <= 1'b0;
      have_data <= 1'b0;
    end else if (up.load) begin
      cap_res   <= up.result;
      cap_dbz   <= up.divbyzero;
      cap_zero  <= up.zero;
      have_data <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      err <= 1'b0;
    end else begin
      an  <= an_next;
      seg <= dig_seg;
      err <= cap_dbz & have_data;
    end
  end

endmodule

// File: tb/tb_result_display_driver.sv
// Randomized and directed bench for result_display_driver; a text-level model
// of the four-character display predicts an/seg/err every cycle.
module tb_result_display_driver;
  localparam int RD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] an;
  logic [6:0] seg;
  logic       err;

  result_display_driver_if bus();

  result_display_driver #(.REFRESH_DIV(RD), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .up    (bus),
    .an    (an),
    .seg   (seg),
    .err   (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  int         m_edges;
  logic       m_hd;
  logic       m_dbz;
  logic       m_zero;
  logic [4:0] m_res;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: observed %b expected %b", tag, $time, got, exp);
    end
  endtask

  // What a person would read on the display, leftmost digit first.
  function automatic string disp_text();
    string s;
    if (!m_hd) return "    ";
    if (m_dbz) return " Err";
    if (m_zero) return "   0";
    s = (m_res[4] && m_res[3:0] != 0) ? "-" : " ";
    return {s, " ", $sformatf("%2d", m_res[3:0])};
  endfunction

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "0": return 7'b1000000;
      "1": return 7'b1111001;
      "2": return 7'b0100100;
      "3": return 7'b0110000;
      "4": return 7'b0011001;
      "5": return 7'b0010010;
      "6": return 7'b0000010;
      "7": return 7'b1111000;
      "8": return 7'b0000000;
      "9": return 7'b0010000;
      "-": return 7'b0111111;
      "E": return 7'b0000110;
      "r": return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_hd    = 1'b0;
    m_dbz   = 1'b0;
    m_zero  = 1'b0;
    m_res   = 5'd0;
  endtask

  // One clock: predict outputs from pre-edge model state, then apply capture.
  task automatic step();
    int d;
    string t;
    @(posedge clk);
    if (rst_n) begin
      d = (m_edges / RD) % 4;
      m_edges++;
      t = disp_text();
      exp_an  = 4'b1111 & ~(4'b0001 << d);
      exp_seg = glyph(t[3-d]);
      exp_err = m_hd && m_dbz;
      if (bus.load) begin
        m_hd   = 1'b1;
        m_res  = bus.result;
        m_dbz  = bus.divbyzero;
        m_zero = bus.zero;
      end
    end else begin
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      exp_err = 1'b0;
    end
    #1;
    check_val("an", {28'd0, an}, {28'd0, exp_an});
    check_val("seg", {25'd0, seg}, {25'd0, exp_seg});
    check_val("err", {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_val(input logic [4:0] r, input logic dbz, input logic z);
    bus.result    = r;
    bus.divbyzero = dbz;
    bus.zero      = z;
    bus.load      = 1'b1;
    step();
    bus.load      = 1'b0;
  endtask

  // Asynchronous assertion away from the clock edge; load is pulsed while held.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_an", {28'd0, an}, 32'hF);
    check_val("rst_seg", {25'd0, seg}, 32'h7F);
    check_val("rst_err", {31'd0, err}, 32'd0);
    bus.load   = 1'b1;
    bus.result = 5'b01001;
    run(3);
    bus.load = 1'b0;
    model_reset();
    rst_n = 1'b1;
  endtask

  int sample_phase;

  initial begin
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.result    = 5'd0;
    bus.divbyzero = 1'b0;
    bus.zero      = 1'b0;
    model_reset();
    run(2);
    rst_n = 1'b1;

    run(7);
    do_reset();
    run(16);

    load_val(5'b10110, 1'b0, 1'b0);
    run(17);
    load_val(5'b01101, 1'b0, 1'b0);
    run(17);
    load_val(5'b10000, 1'b1, 1'b1);
    check_val("err_pre", {31'd0, err}, 32'd0);
    step();
    check_val("err_set", {31'd0, err}, 32'd1);
    run(16);
    load_val(5'b00001, 1'b0, 1'b0);
    step();
    check_val("err_clr", {31'd0, err}, 32'd0);
    run(16);
    load_val(5'b10000, 1'b0, 1'b1);
    run(17);

    // back-to-back loads: last one wins, phase untouched
    sample_phase = m_edges % (4 * RD);
    bus.result = 5'b00010; bus.divbyzero = 1'b0; bus.zero = 1'b0; bus.load = 1'b1;
    step();
    bus.result = 5'b01001;
    step();
    bus.load = 1'b0;
    run(16);
    check_val("phase", (m_edges - sample_phase) % (4 * RD), 32'd18 % (4 * RD));

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.result    = 5'($urandom_range(0, 31));
        bus.divbyzero = ($urandom_range(0, 3) == 0);
        bus.zero      = ($urandom_range(0, 3) == 0);
        bus.load      = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      step();
    end
    bus.load = 1'b0;

    run(5);
    do_reset();
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
